// File: rtl/sim_run_ctrl.sv
// Run controller: staged core reset release, cycle/retire counting,
// halt detection with pipeline drain, and pass/timeout verdict.
module sim_run_ctrl #(
    parameter int NUM_CORES      = 1,
    parameter int RST_CYCLES     = 4,
    parameter int STAGGER        = 0,
    parameter int DRAIN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                           clk,
    input  logic                           rst_,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_halt,
    input  logic [NUM_CORES-1:0]           core_retire,
    output logic [NUM_CORES-1:0]           core_hold,
    output logic [CNT_WIDTH-1:0]           cycle_count,
    output logic [NUM_CORES*CNT_WIDTH-1:0] retire_count,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam int LAST_REL = RST_CYCLES + (NUM_CORES - 1) * STAGGER;
    localparam int PH_MAX   = (LAST_REL > DRAIN_CYCLES) ? LAST_REL : DRAIN_CYCLES;
    localparam int PH_W     = $clog2(PH_MAX + 1);
    localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d, phase_inc;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [NUM_CORES-1:0] halt_seen_q, halt_seen_d;
    logic [NUM_CORES-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [NUM_CORES-1:0][CNT_WIDTH-1:0] ret_q, ret_d;
    logic busy_q, busy_d, done_q, done_d;
    logic pass_q, pass_d, to_q, to_d;

    logic [NUM_CORES-1:0] live, halt_now;
    logic all_halt, wd_hit, drain_end;

    assign live      = ~hold_q;
    assign halt_now  = halt_seen_q | (core_halt & live);
    assign all_halt  = &halt_now;
    assign wd_hit    = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign drain_end = (phase_q == PH_W'(DRAIN_CYCLES - 1));
    assign phase_inc = phase_q + PH_W'(1);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            wdog_q      <= '0;
            halt_seen_q <= '0;
            hold_q      <= '1;
            cyc_q       <= '0;
            ret_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wdog_q      <= wdog_d;
            halt_seen_q <= halt_seen_d;
            hold_q      <= hold_d;
            cyc_q       <= cyc_d;
            ret_q       <= ret_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            to_q        <= to_d;
        end
    end

    // Halt beats watchdog when both land on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RESET;
            S_RESET: if (phase_inc >= PH_W'(LAST_REL)) state_d = S_RUN;
            S_RUN: begin
                if (all_halt)    state_d = S_DRAIN;
                else if (wd_hit) state_d = S_DONE;
            end
            S_DRAIN: if (drain_end) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        wdog_d      = wdog_q;
        halt_seen_d = halt_seen_q;
        cyc_d       = cyc_q;
        ret_d       = ret_q;
        pass_d      = pass_q;
        to_d        = to_q;
        if (state_q == S_IDLE || state_q == S_DONE) begin
            if (start) begin
                phase_d     = '0;
                wdog_d      = '0;
                halt_seen_d = '0;
                cyc_d       = '0;
                ret_d       = '0;
                pass_d      = 1'b0;
                to_d        = 1'b0;
            end
        end else begin
            halt_seen_d = halt_now;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_retire[i] && live[i] && ret_q[i] != CNT_MAX)
                    ret_d[i] = ret_q[i] + CNT_WIDTH'(1);
            end
            if ((state_q == S_RUN || state_q == S_DRAIN) && cyc_q != CNT_MAX)
                cyc_d = cyc_q + CNT_WIDTH'(1);
            if (state_q == S_RESET) phase_d = phase_inc;
            if (state_q == S_RUN) begin
                wdog_d = wdog_q + WD_W'(1);
                if (state_d == S_DRAIN) phase_d = '0;
                if (state_d == S_DONE)  to_d = 1'b1;
            end
            if (state_q == S_DRAIN) begin
                phase_d = phase_inc;
                if (drain_end) pass_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = (state_d == S_RESET || state_d == S_RUN || state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        hold_d = '1;
        if (state_d == S_RESET) begin
            for (int i = 0; i < NUM_CORES; i++)
                hold_d[i] = (phase_d < PH_W'(RST_CYCLES + i * STAGGER));
        end else if (state_d == S_RUN || state_d == S_DRAIN) begin
            hold_d = '0;
        end
    end

    assign core_hold    = hold_q;
    assign cycle_count  = cyc_q;
    assign retire_count = ret_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: three instances cover the single-core,
// staggered four-core and narrow-counter configurations.
module tb_sim_run_ctrl;

    typedef struct packed {
        logic [1:0]       s;
        logic [31:0]      at;
        logic             ps;
        logic             to;
        logic [31:0]      cyc;
        logic [3:0][31:0] ret;
        logic [3:0]       hold;
    } exp_t;

    typedef struct packed {
        logic [1:0]  s;
        logic [1:0]  core;
        logic [31:0] at;
    } rel_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_;
    logic       st_in   [3];
    logic [3:0] halt_in [3];
    logic [3:0] ret_in  [3];

    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic       to_o   [3];
    logic [0:0]   hold0, hold2;
    logic [3:0]   hold1;
    logic [31:0]  cyc0, cyc1, rc0;
    logic [3:0]   cyc2, rc2;
    logic [127:0] rc1;

    logic [3:0]  hold_o [3];
    logic [31:0] cyc_o  [3];
    logic [31:0] ret_o  [3][4];
    logic [3:0]  mask   [3];

    sim_run_ctrl #(.NUM_CORES(1), .TIMEOUT_CYCLES(50)) u0 (
        .clk(clk), .rst_(rst_), .start(st_in[0]),
        .core_halt(halt_in[0][0:0]), .core_retire(ret_in[0][0:0]),
        .core_hold(hold0), .cycle_count(cyc0), .retire_count(rc0),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .timeout(to_o[0])
    );

    sim_run_ctrl #(.NUM_CORES(4), .STAGGER(2)) u1 (
        .clk(clk), .rst_(rst_), .start(st_in[1]),
        .core_halt(halt_in[1]), .core_retire(ret_in[1]),
        .core_hold(hold1), .cycle_count(cyc1), .retire_count(rc1),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .timeout(to_o[1])
    );

    sim_run_ctrl #(.NUM_CORES(1), .CNT_WIDTH(4)) u2 (
        .clk(clk), .rst_(rst_), .start(st_in[2]),
        .core_halt(halt_in[2][0:0]), .core_retire(ret_in[2][0:0]),
        .core_hold(hold2), .cycle_count(cyc2), .retire_count(rc2),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .timeout(to_o[2])
    );

    always_comb begin
        hold_o[0] = {3'b0, hold0};
        hold_o[1] = hold1;
        hold_o[2] = {3'b0, hold2};
        cyc_o[0]  = cyc0;
        cyc_o[1]  = cyc1;
        cyc_o[2]  = {28'b0, cyc2};
        for (int c = 0; c < 4; c++) begin
            ret_o[0][c] = (c == 0) ? rc0 : 32'd0;
            ret_o[1][c] = rc1[c*32 +: 32];
            ret_o[2][c] = (c == 0) ? {28'b0, rc2} : 32'd0;
        end
        mask[0] = 4'h1;
        mask[1] = 4'hF;
        mask[2] = 4'h1;
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q [$];
    rel_t rel_q [$];

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    logic [3:0] hold_prev [3];
    logic       done_prev [3];
    bit         mon_en = 1'b0;
    rel_t       mr;
    exp_t       mx;

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (mon_en) begin
                for (int c = 0; c < 4; c++) begin
                    if (hold_prev[s][c] && !hold_o[s][c]) begin
                        if (rel_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL rel_unexpected: inst %0d core %0d at edge %0d, expected none",
                                     s, c, edge_n);
                        end else begin
                            mr = rel_q.pop_front();
                            chk("rel_inst", s, mr.s);
                            chk("rel_core", c, mr.core);
                            chk("rel_edge", edge_n, mr.at);
                        end
                    end
                end
                if (done_o[s] && !done_prev[s]) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL done_unexpected: inst %0d at edge %0d, expected none", s, edge_n);
                    end else begin
                        mx = exp_q.pop_front();
                        chk("done_inst", s, mx.s);
                        chk("done_edge", edge_n, mx.at);
                        chk("pass", pass_o[s], mx.ps);
                        chk("timeout", to_o[s], mx.to);
                        chk("cycle_count", cyc_o[s], mx.cyc);
                        for (int c = 0; c < 4; c++) chk("retire_count", ret_o[s][c], mx.ret[c]);
                        chk("hold_at_done", hold_o[s], mx.hold);
                        chk("busy_at_done", busy_o[s], 0);
                    end
                end
            end
            hold_prev[s] = hold_o[s];
            done_prev[s] = done_o[s];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) step();
    endtask

    task automatic clear_in(input int s);
        st_in[s]   = 1'b0;
        halt_in[s] = 4'h0;
        ret_in[s]  = 4'h0;
    endtask

    task automatic pulse_start(input int s, output int k);
        step();
        st_in[s] = 1'b1;
        k = edge_n + 1;
        step();
        st_in[s] = 1'b0;
    endtask

    task automatic push_rel(input int s, input int c, input int at);
        rel_t r;
        r.s = 2'(s);
        r.core = 2'(c);
        r.at = 32'(at);
        rel_q.push_back(r);
    endtask

    task automatic push_done(input int s, input int at, input bit ps, input bit to,
                             input int cyc, input int r0, input int r1,
                             input int r2, input int r3);
        exp_t x;
        x.s = 2'(s);
        x.at = 32'(at);
        x.ps = ps;
        x.to = to;
        x.cyc = 32'(cyc);
        x.ret[0] = 32'(r0);
        x.ret[1] = 32'(r1);
        x.ret[2] = 32'(r2);
        x.ret[3] = 32'(r3);
        x.hold = mask[s];
        exp_q.push_back(x);
    endtask

    // 20 RUN cycles, 12 retires, halt on the 20th; a stray start mid-run is ignored.
    task automatic scen_default();
        int k, e;
        pulse_start(0, k);
        e = k + 4;
        push_rel(0, 0, e);
        push_done(0, e + 25, 1, 0, 25, 12, 0, 0, 0);
        wait_edge(e);
        for (int j = 1; j <= 20; j++) begin
            ret_in[0]  = (j <= 12) ? 4'h1 : 4'h0;
            halt_in[0] = (j == 20) ? 4'h1 : 4'h0;
            st_in[0]   = (j == 5);
            step();
        end
        clear_in(0);
        wait_edge(e + 30);
    endtask

    task automatic scen_timeout();
        int k, e;
        pulse_start(0, k);
        e = k + 4;
        push_rel(0, 0, e);
        push_done(0, e + 50, 0, 1, 50, 3, 0, 0, 0);
        wait_edge(e);
        for (int j = 1; j <= 3; j++) begin
            ret_in[0] = 4'h1;
            step();
        end
        clear_in(0);
        wait_edge(e + 55);
    endtask

    task automatic scen_simul();
        int k, e;
        pulse_start(0, k);
        e = k + 4;
        push_rel(0, 0, e);
        push_done(0, e + 55, 1, 0, 55, 0, 0, 0, 0);
        wait_edge(e + 49);
        halt_in[0] = 4'h1;
        step();
        clear_in(0);
        wait_edge(e + 60);
    endtask

    task automatic scen_rst();
        int k, e;
        pulse_start(0, k);
        e = k + 4;
        push_rel(0, 0, e);
        wait_edge(e);
        for (int j = 1; j <= 10; j++) begin
            ret_in[0] = 4'h1;
            step();
        end
        clear_in(0);
        wait_edge(e + 29);
        rst_ = 1'b1;
        step();
        chk("rst_busy", busy_o[0], 0);
        chk("rst_done", done_o[0], 0);
        chk("rst_hold", hold_o[0], 1);
        chk("rst_cycle_count", cyc_o[0], 0);
        chk("rst_retire_count", ret_o[0][0], 0);
        chk("rst_pass", pass_o[0], 0);
        chk("rst_timeout", to_o[0], 0);
        rst_ = 1'b0;
    endtask

    // Strobes on held cores during the reset window must be dropped.
    task automatic scen_stagger();
        int k, e;
        pulse_start(1, k);
        for (int c = 0; c < 4; c++) push_rel(1, c, k + 4 + 2 * c);
        e = k + 10;
        push_done(1, e + 11, 1, 0, 11, 1, 2, 3, 4);
        for (int j = 1; j <= 3; j++) begin
            ret_in[1]  = 4'hF;
            halt_in[1] = 4'hF;
            step();
        end
        clear_in(1);
        wait_edge(e);
        for (int j = 1; j <= 6; j++) begin
            for (int c = 0; c < 4; c++) ret_in[1][c] = (j <= c + 1);
            halt_in[1] = {j == 6, j == 4, j == 3, j == 2};
            step();
        end
        clear_in(1);
        wait_edge(e + 15);
    endtask

    task automatic scen_sat();
        int k, e;
        pulse_start(2, k);
        e = k + 4;
        push_rel(2, 0, e);
        push_done(2, e + 45, 1, 0, 15, 15, 0, 0, 0);
        wait_edge(e);
        for (int j = 1; j <= 40; j++) begin
            ret_in[2]  = 4'h1;
            halt_in[2] = (j == 40) ? 4'h1 : 4'h0;
            step();
        end
        clear_in(2);
        wait_edge(e + 50);
        pulse_start(2, k);
        e = k + 4;
        push_rel(2, 0, e);
        push_done(2, e + 9, 1, 0, 9, 3, 0, 0, 0);
        wait_edge(e);
        for (int j = 1; j <= 4; j++) begin
            ret_in[2]  = (j <= 3) ? 4'h1 : 4'h0;
            halt_in[2] = (j == 4) ? 4'h1 : 4'h0;
            step();
        end
        clear_in(2);
        wait_edge(e + 15);
    endtask

    initial begin
        rst_ = 1'b1;
        for (int s = 0; s < 3; s++) clear_in(s);
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            chk("init_busy", busy_o[s], 0);
            chk("init_done", done_o[s], 0);
            chk("init_pass", pass_o[s], 0);
            chk("init_timeout", to_o[s], 0);
            chk("init_hold", hold_o[s], mask[s]);
            chk("init_cycle_count", cyc_o[s], 0);
            chk("init_retire_count", ret_o[s][0], 0);
        end
        rst_ = 1'b0;
        mon_en = 1'b1;
        scen_default();
        scen_timeout();
        scen_simul();
        scen_rst();
        scen_default();
        scen_stagger();
        scen_sat();
        repeat (5) step();
        chk("pending_release", rel_q.size(), 0);
        chk("pending_done", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
